// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction field positions, default widths and the
// major-opcode encoding seen by both the fetch stage and the Control_Unit.
package isa_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 27;
  localparam int ALUOP_MSB = 26;
  localparam int ALUOP_LSB = 24;

  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
  localparam int ALUOP_W = ALUOP_MSB - ALUOP_LSB + 1;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [OPC_W-1:0] {
    OPC_ALU   = 5'b00000,
    OPC_ADDI  = 5'b00001,
    OPC_LOAD  = 5'b00100,
    OPC_STORE = 5'b00101,
    OPC_BEQ   = 5'b01000,
    OPC_BNE   = 5'b01001,
    OPC_JMP   = 5'b10000,
    OPC_JAL   = 5'b10001,
    OPC_JR    = 5'b10010
  } opcode_e;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } aluop_e;

  function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [ALUOP_W-1:0] get_aluop(input logic [INSTR_W-1:0] instr);
    return instr[ALUOP_MSB:ALUOP_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with load enable, flush and synchronous reset.
// Flush only kills the valid bit; the payload is don't-care while invalid.
module if_id_reg #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // Flush outranks the enable so a redirect during a stall still empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous instruction
// memory and loads the IF/ID register feeding the decode-stage Control_Unit.
module fetch_stage
  import isa_pkg::*;
#(
  parameter int                PC_W     = isa_pkg::PC_W,
  parameter int                INSTR_W  = isa_pkg::INSTR_W,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter int                PC_INC   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [OPC_W-1:0]   id_opcode,
  output logic [ALUOP_W-1:0] id_aluop
);

  localparam int ID_W = PC_W + INSTR_W;

  logic [PC_W-1:0] r_pc;
  logic            r_req_valid;
  logic [PC_W-1:0] r_req_pc;

  logic [PC_W-1:0] w_fetch_addr;
  logic            w_fetch;
  logic [ID_W-1:0] w_id_d;
  logic [ID_W-1:0] w_id_q;

  // A redirect issues its target immediately, so it fetches even when stalled.
  assign w_fetch_addr = redirect_valid ? redirect_pc : r_pc;
  assign w_fetch      = redirect_valid | ~stall;

  assign imem_addr = w_fetch_addr;
  assign imem_en   = ~rst & w_fetch;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else if (w_fetch) begin
      r_req_valid <= 1'b1;
      r_req_pc    <= w_fetch_addr;
      r_pc        <= w_fetch_addr + PC_W'(PC_INC);
    end
  end

  // While stalled imem_en is low, so imem_rdata still holds the in-flight word.
  assign w_id_d = {r_req_pc, imem_rdata};

  if_id_reg #(
    .DATA_W (ID_W)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_en    (~stall),
    .i_flush (redirect_valid),
    .i_valid (r_req_valid),
    .i_data  (w_id_d),
    .o_valid (id_valid),
    .o_data  (w_id_q)
  );

  assign id_pc     = w_id_q[ID_W-1:INSTR_W];
  assign id_instr  = w_id_q[INSTR_W-1:0];
  assign id_opcode = id_instr[OPC_MSB:OPC_LSB];
  assign id_aluop  = id_instr[ALUOP_MSB:ALUOP_LSB];

endmodule
